// File: rtl/sram22_rr_port_arbiter_if.sv
// Client-side bundle for the two-port sram22 arbiter: per-port request handshake plus
// shared read-response bus. The arbiter is the slave; the bus clients are the master.
`timescale 1ns/1ps
interface sram22_rr_port_arbiter_if #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int WMASK_WIDTH = 4
);
  logic [1:0]                  rq_valid;
  logic [1:0]                  rq_ready;
  logic [1:0]                  rq_we;
  logic [1:0][WMASK_WIDTH-1:0] rq_wmask;
  logic [1:0][ADDR_WIDTH-1:0]  rq_addr;
  logic [1:0][DATA_WIDTH-1:0]  rq_wdata;
  logic [1:0]                  rsp_valid;
  logic [DATA_WIDTH-1:0]       rsp_rdata;

  modport master (
    output rq_valid, rq_we, rq_wmask, rq_addr, rq_wdata,
    input  rq_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  rq_valid, rq_we, rq_wmask, rq_addr, rq_wdata,
    output rq_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sram22_rr_port_arbiter.sv
// Round-robin two-port front end for a single-port sram22 macro with a registered read,
// optionally zero-filling the whole array after reset before serving requests.
`timescale 1ns/1ps
module sram22_rr_port_arbiter #(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int WMASK_WIDTH    = 4,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  sram22_rr_port_arbiter_if.slave bus,
  output logic                   init_done,
  output logic                   sram_rstb,
  output logic                   sram_ce,
  output logic                   sram_we,
  output logic [WMASK_WIDTH-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_din,
  input  logic [DATA_WIDTH-1:0]  sram_dout
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [0:0] ST_RESET = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
  localparam logic [ADDR_WIDTH:0] CLR_LAST = (ADDR_WIDTH+1)'(DEPTH - 1);

  logic [0:0]          state_q, state_d;
  logic [ADDR_WIDTH:0] clr_addr_q, clr_addr_d;
  logic                last_grant_q, last_grant_d;
  logic [1:0]          rsp_valid_q, rsp_valid_d;
  logic                sram_rstb_q;

  logic       grant_port;
  logic       serving;
  logic       accept;
  logic [1:0] ready;

  // Contention goes to whichever port did not win last; a lone requester always wins.
  always_comb begin
    grant_port = bus.rq_valid[1];
    if (bus.rq_valid == 2'b11) begin
      grant_port = ~last_grant_q;
    end
  end

  assign serving = (state_q == ST_RUN) && !rst;
  assign accept  = serving && (|bus.rq_valid);
  assign ready   = accept ? (grant_port ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    sram_ce    = 1'b0;
    sram_we    = 1'b0;
    sram_wmask = '0;
    sram_addr  = '0;
    sram_din   = '0;
    if (!rst && state_q == ST_INIT) begin
      sram_ce    = 1'b1;
      sram_we    = 1'b1;
      sram_wmask = '1;
      sram_addr  = clr_addr_q[ADDR_WIDTH-1:0];
    end else if (accept) begin
      sram_ce    = 1'b1;
      sram_we    = bus.rq_we[grant_port];
      sram_wmask = bus.rq_wmask[grant_port];
      sram_addr  = bus.rq_addr[grant_port];
      sram_din   = bus.rq_wdata[grant_port];
    end
  end

  always_comb begin
    state_d      = state_q;
    clr_addr_d   = clr_addr_q;
    last_grant_d = last_grant_q;
    rsp_valid_d  = ready & ~bus.rq_we;
    if (state_q == ST_INIT) begin
      clr_addr_d = clr_addr_q + 1'b1;
      if (clr_addr_q == CLR_LAST) begin
        state_d = ST_RUN;
      end
    end
    if (accept) begin
      last_grant_d = grant_port;
    end
  end

  // Reset also drops any read response that was in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RESET;
      clr_addr_q   <= '0;
      last_grant_q <= 1'b1;
      rsp_valid_q  <= 2'b00;
      sram_rstb_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      sram_rstb_q  <= 1'b1;
    end
  end

  assign bus.rq_ready  = ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = sram_dout;
  assign sram_rstb     = sram_rstb_q;
  assign init_done     = serving;
endmodule
